instr_encoder_loader: RTL
=========================

# instr_encoder_loader

Program loader that encodes field-level instruction commands (cond, op, funct, rn, rd, imm) into 32-bit ARM-format words and writes them sequentially into instruction memory. It is the encoding counterpart of the processor's instruction decoder: it packs the same Op/Funct/Rd/Rn fields the control unit later unpacks. While loading, it holds the multicycle core idle; it releases the core when the last word is written.

## Interface
Parameters:
- BASE_ADDR, 32'h0000_0000: byte address of the first word written.
- DEPTH, 64: maximum number of words per load session.

Ports:
- clk  in  1  single clock; all state on the rising edge.
- reset  in  1  asynchronous, active-low; all state is cleared while low.
- start  in  1  pulse that begins a load session; honoured only in IDLE.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_last  in  1  marks the final command of the session.
- cmd_cond  in  4  condition field, bits [31:28].
- cmd_op  in  2  op field, bits [27:26].
- cmd_funct  in  6  funct field.
- cmd_rn  in  4  Rn field.
- cmd_rd  in  4  Rd field.
- cmd_imm  in  24  immediate/src2 field, or branch offset.
- MemWE  out  1  instruction-memory write enable.
- Adr  out  32  write byte address.
- WriteData  out  32  encoded instruction word.
- mem_ack  in  1  memory accepted the write this cycle.
- cpu_hold  out  1  holds the core idle while high.
- done  out  1  one-cycle pulse at session end.
- err  out  1  sticky error flag; cleared by start.
- count  out  $clog2(DEPTH+1)  words written in this session.

## Operation
Encoding is combinational on the accepted command and is registered into WriteData on acceptance:
- op=00 or 01: {cond, op, funct, rn, rd, imm[11:0]}.
- op=10: {cond, 2'b10, funct[5:4], imm[23:0]}. Rn and Rd are ignored.
- op=11: illegal. The command is accepted, err is set, and nothing is written.

FSM states are IDLE, LOAD, WRITE and DONE.
- IDLE: cmd_ready=0, cpu_hold=0.
  - On start: Adr<=BASE_ADDR, count<=0, err<=0, cpu_hold<=1, go to LOAD.
- LOAD: cmd_ready=1.
  - On handshake with a legal op and count<DEPTH: latch WriteData, go to WRITE.
  - On handshake with an illegal op, or with count==DEPTH (full): set err and drop the word. Go to DONE if cmd_last, otherwise stay in LOAD.
- WRITE: MemWE=1, cmd_ready=0. Adr and WriteData are held stable until mem_ack.
  - On mem_ack: Adr<=Adr+4, count<=count+1. Go to DONE if the latched last flag is set, otherwise go to LOAD.
- DONE: done=1 for exactly one cycle, cpu_hold<=0, go to IDLE.

Boundary conditions:
- start outside IDLE is ignored.
- Adr wraps modulo 2^32. No check is made beyond DEPTH-based fullness.
- count saturates at DEPTH.
- cmd_last on a dropped command still ends the session.
- Reset low mid-session aborts immediately. The partial image stays in memory, and MemWE drops asynchronously.

## Timing
Reset values:
- cmd_ready=0, MemWE=0, cpu_hold=0, done=0, err=0, count=0.
- Adr=BASE_ADDR, WriteData=0, state IDLE.

Latencies:
- start in cycle N gives cpu_hold=1 and cmd_ready=1 in cycle N+1.
- Acceptance in cycle N gives MemWE=1 with valid Adr/WriteData in cycle N+1.
- mem_ack in the same cycle as MemWE gives cmd_ready=1 again the next cycle. Best-case throughput is one word per 2 cycles.
- mem_ack wait states extend WRITE indefinitely.
- The last write acked in cycle M gives done=1 and cpu_hold still 1 in M+1, and cpu_hold=0 in M+2.
- All outputs are registered except cmd_ready and MemWE, which decode from state only.

## Test plan
- ADD with cond=E, op=00, funct=101000, rn=2, rd=1, imm=5, last=1, mem_ack tied 1 -> one write of WriteData=32'hE2821005 at Adr=0. Then done pulse, count=1, cpu_hold falls 2 cycles after the ack.
- Three commands: LDR (op=01, funct=011001, rn=0, rd=3, imm=8), then the ADD above, then B (op=10, funct=10xxxx, imm=FFFFFE, last) -> writes E5903008@0, E2821005@4, EAFFFFFE@8. count=3, err=0.
- Illegal op=11 between two legal commands -> err=1, only 2 writes, at addresses 0 and 4 (no address gap).
- DEPTH=2 with 3 commands -> third command dropped, err=1, count=2. Session still ends on cmd_last.
- mem_ack delayed 3 cycles -> MemWE, Adr and WriteData held stable for 4 cycles, and cmd_ready stays 0 throughout.
- reset pulsed low during WRITE -> MemWE=0 and cpu_hold=0 immediately. After reset rises, a new start restarts at BASE_ADDR with count=0.

Source files
------------

// File: rtl/instr_encoder_loader_if.sv
// Command and instruction-memory bus between a program host and the encoder/loader.
// slave is the loader's view; master is the host/memory side.
interface instr_encoder_loader_if #(
    parameter int unsigned DEPTH = 64
) ();
    localparam int unsigned COUNT_W = $clog2(DEPTH + 1);

    logic               start;
    logic               cmd_valid;
    logic               cmd_ready;
    logic               cmd_last;
    logic [3:0]         cmd_cond;
    logic [1:0]         cmd_op;
    logic [5:0]         cmd_funct;
    logic [3:0]         cmd_rn;
    logic [3:0]         cmd_rd;
    logic [23:0]        cmd_imm;
    logic               MemWE;
    logic [31:0]        Adr;
    logic [31:0]        WriteData;
    logic               mem_ack;
    logic               cpu_hold;
    logic               done;
    logic               err;
    logic [COUNT_W-1:0] count;

    modport slave (
        input  start, cmd_valid, cmd_last, cmd_cond, cmd_op, cmd_funct, cmd_rn, cmd_rd, cmd_imm,
        input  mem_ack,
        output cmd_ready, MemWE, Adr, WriteData, cpu_hold, done, err, count
    );

    modport master (
        output start, cmd_valid, cmd_last, cmd_cond, cmd_op, cmd_funct, cmd_rn, cmd_rd, cmd_imm,
        output mem_ack,
        input  cmd_ready, MemWE, Adr, WriteData, cpu_hold, done, err, count
    );
endinterface

// File: rtl/instr_encoder_loader.sv
// Encodes field-level commands into 32-bit ARM-format words and writes them sequentially
// into instruction memory, holding the core idle for the duration of the load.
module instr_encoder_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned DEPTH     = 64
) (
    input logic                   clk,
    input logic                   reset,
    instr_encoder_loader_if.slave bus
);
    localparam int unsigned COUNT_W = $clog2(DEPTH + 1);
    localparam logic [COUNT_W-1:0] FULL = COUNT_W'(DEPTH);

    typedef enum logic [1:0] {StIdle, StLoad, StWrite, StDone} state_e;

    state_e               state_q, state_d;
    logic [31:0]          adr_q, adr_d;
    logic [31:0]          wdata_q, wdata_d;
    logic [COUNT_W-1:0]   count_q, count_d;
    logic                 err_q, err_d;
    logic                 hold_q, hold_d;
    logic                 done_q, done_d;
    logic                 last_q, last_d;
    logic [31:0]          encoded;
    logic                 accept, legal, full, write_ok, drop;

    assign accept   = (state_q == StLoad) && bus.cmd_valid;
    assign legal    = (bus.cmd_op != 2'b11);
    assign full     = (count_q == FULL);
    assign write_ok = accept && legal && !full;
    assign drop     = accept && (!legal || full);

    always_comb begin
        encoded = '0;
        case (bus.cmd_op)
            2'b00, 2'b01: encoded = {bus.cmd_cond, bus.cmd_op, bus.cmd_funct,
                                     bus.cmd_rn, bus.cmd_rd, bus.cmd_imm[11:0]};
            // Branch: only the link/type bits of funct survive next to the 24-bit offset.
            2'b10:        encoded = {bus.cmd_cond, 2'b10, bus.cmd_funct[5:4], bus.cmd_imm};
            default:      encoded = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (bus.start) state_d = StLoad;
            StLoad: begin
                if (write_ok) begin
                    state_d = StWrite;
                end else if (drop && bus.cmd_last) begin
                    state_d = StDone;
                end
            end
            StWrite: if (bus.mem_ack) state_d = last_q ? StDone : StLoad;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Decoded from state only so MemWE falls the instant reset is asserted.
    always_comb begin
        bus.cmd_ready = (state_q == StLoad);
        bus.MemWE     = (state_q == StWrite);
    end

    always_comb begin
        adr_d   = adr_q;
        wdata_d = wdata_q;
        count_d = count_q;
        err_d   = err_q;
        hold_d  = hold_q;
        last_d  = last_q;
        done_d  = 1'b0;
        case (state_q)
            StIdle: begin
                if (bus.start) begin
                    adr_d   = BASE_ADDR;
                    count_d = '0;
                    err_d   = 1'b0;
                    hold_d  = 1'b1;
                end
            end
            StLoad: begin
                if (write_ok) begin
                    wdata_d = encoded;
                    last_d  = bus.cmd_last;
                end
                if (drop) begin
                    err_d = 1'b1;
                    if (bus.cmd_last) done_d = 1'b1;
                end
            end
            StWrite: begin
                if (bus.mem_ack) begin
                    adr_d = adr_q + 32'd4;
                    if (!full) count_d = count_q + COUNT_W'(1);
                    if (last_q) done_d = 1'b1;
                end
            end
            StDone:  hold_d = 1'b0;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            adr_q   <= BASE_ADDR;
            wdata_q <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
            hold_q  <= 1'b0;
            done_q  <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            adr_q   <= adr_d;
            wdata_q <= wdata_d;
            count_q <= count_d;
            err_q   <= err_d;
            hold_q  <= hold_d;
            done_q  <= done_d;
            last_q  <= last_d;
        end
    end

    assign bus.Adr       = adr_q;
    assign bus.WriteData = wdata_q;
    assign bus.count     = count_q;
    assign bus.err       = err_q;
    assign bus.cpu_hold  = hold_q;
    assign bus.done      = done_q;

endmodule
